btb_predictor: RTL and testbench

- Parametrised next-PC predictor for the pipelined CPU fetch stage.
- Provides a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Predicts nextPC combinationally from the fetch PC. The table is trained by resolved-branch updates from the execute stage on the clock edge.
- forcePC override for redirect on mispredict is retained.

---
 rtl/btb_predictor.sv | 142 ++++++++++++++
 tb/tb_btb_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped BTB next-PC predictor with saturating direction counters
//
// Purpose: predicts the next fetch PC combinationally from the fetch PC.
// Each table entry has a valid bit, a tag, a target and a direction counter.
// Resolved-branch updates from execute train the table on the clock edge.
// A forcePC redirect overrides the prediction.
//
// Optional feature: define BTB_STATS_EN to add the lookup, hit and
// mispredict statistics counters and their output ports.
//
// Ports:
//   clk, reset                   rising-edge clock, async active-high reset
//   PC                           fetch PC to predict for
//   nextPC                       predicted or forced next fetch PC
//   pred_hit / pred_taken        tag hit / predicted-taken flags for PC
//   forcePC / forcePCdata        redirect request and its target
//   upd_valid, upd_is_branch,
//   upd_pc, upd_taken,
//   upd_target, upd_mispredict   resolved-instruction update bundle
//   stat_lookups, stat_hits,
//   stat_mispredicts             statistics (BTB_STATS_EN only)
module btb_predictor #(
  parameter int WORD_SIZE   = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 2,
  parameter int STAT_W      = 16,
  localparam int IDX_W      = $clog2(BTB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] nextPC,
  output logic                 pred_hit,
  output logic                 pred_taken,
  input  logic                 forcePC,
  input  logic [WORD_SIZE-1:0] forcePCdata,
  input  logic                 upd_valid,
  input  logic                 upd_is_branch,
  input  logic [WORD_SIZE-1:0] upd_pc,
  input  logic                 upd_taken,
  input  logic [WORD_SIZE-1:0] upd_target,
  input  logic                 upd_mispredict
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_lookups,
  output logic [STAT_W-1:0]    stat_hits,
  output logic [STAT_W-1:0]    stat_mispredicts
`endif
);

  localparam int TAG_W = WORD_SIZE - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [WORD_SIZE-1:0]   target_q [BTB_ENTRIES];
  logic [CNT_W-1:0]       cnt_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             upd_hit;

  assign idx   = PC[IDX_W-1:0];
  assign tag   = PC[WORD_SIZE-1:IDX_W];
  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[WORD_SIZE-1:IDX_W];

  assign upd_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup reads registered state only, so an update on this edge is not
  // seen until the following cycle.
  always_comb begin
    pred_hit   = !reset && valid_q[idx] && (tag_q[idx] == tag);
    pred_taken = pred_hit && cnt_q[idx][CNT_W-1];
    if (reset)
      nextPC = '0;
    else if (forcePC)
      nextPC = forcePCdata;
    else if (pred_taken)
      nextPC = target_q[idx];
    else
      nextPC = PC + WORD_SIZE'(1);
  end

  // Valid bits are the only table state that needs clearing on reset;
  // stale tags/targets/counters are masked by valid=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_is_branch && !upd_hit && upd_taken)
        valid_q[u_idx] <= 1'b1;
      else if (!upd_is_branch && upd_hit)
        valid_q[u_idx] <= 1'b0;
    end
  end

  // Entry payload: gated by reset so an update coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_is_branch) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (cnt_q[u_idx] != CNT_MAX)
            cnt_q[u_idx] <= cnt_q[u_idx] + CNT_W'(1);
        end else if (cnt_q[u_idx] != '0) begin
          cnt_q[u_idx] <= cnt_q[u_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        cnt_q[u_idx]    <= CNT_WEAK;
      end
    end
  end

`ifdef BTB_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!forcePC && stat_lookups != STAT_MAX)
        stat_lookups <= stat_lookups + STAT_W'(1);
      if (!forcePC && pred_hit && stat_hits != STAT_MAX)
        stat_hits <= stat_hits + STAT_W'(1);
      if (upd_valid && upd_mispredict && stat_mispredicts != STAT_MAX)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
`else
  logic unused_sink;
  assign unused_sink = ^{upd_mispredict, (STAT_W == 0)};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - self-checking bench for btb_predictor
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] PC;
  logic [15:0] nextPC;
  logic        pred_hit;
  logic        pred_taken;
  logic        forcePC;
  logic [15:0] forcePCdata;
  logic        upd_valid;
  logic        upd_is_branch;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_mispredict;
`ifdef BTB_STATS_EN
  logic [1:0]  stat_lookups;
  logic [1:0]  stat_hits;
  logic [1:0]  stat_mispredicts;
`endif

  always #5 clk = ~clk;

  btb_predictor #(
    .WORD_SIZE(16),
    .BTB_ENTRIES(16),
    .CNT_W(2),
    .STAT_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PC(PC),
    .nextPC(nextPC),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .forcePC(forcePC),
    .forcePCdata(forcePCdata),
    .upd_valid(upd_valid),
    .upd_is_branch(upd_is_branch),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_mispredict(upd_mispredict)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_hits(stat_hits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    logic [15:0] pc;
    logic        fp;
    logic [15:0] fpd;
    logic        uv;
    logic        ub;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic [15:0] exp_next;
    logic        exp_hit;
    logic        exp_taken;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] exp_next;
    logic        exp_hit;
    logic        exp_taken;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] pc, input logic fp, input logic [15:0] fpd,
                     input logic uv, input logic ub, input logic [15:0] upc,
                     input logic ut, input logic [15:0] utgt,
                     input logic [15:0] en, input logic eh, input logic et);
    vec_t v;
    v.pc = pc; v.fp = fp; v.fpd = fpd; v.uv = uv; v.ub = ub; v.upc = upc;
    v.ut = ut; v.utgt = utgt; v.exp_next = en; v.exp_hit = eh; v.exp_taken = et;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    forcePC = 1'b0; forcePCdata = 16'h0000;
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_pc = 16'h0000;
    upd_taken = 1'b0; upd_target = 16'h0000; upd_mispredict = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    PC = 16'h0010;
    idle_inputs();

    //      pc     fp fpd    uv ub upc    ut utgt     next   hit tkn
    add(16'h0010, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0011, 0, 0);
    add(16'h0010, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0011, 0, 0);
    add(16'h0023, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0040, 1, 1);
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 0, 16'h0,    16'h0040, 1, 1); // same-cycle: old cnt 2
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 0, 16'h0,    16'h0024, 1, 0); // cnt 1
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 0, 16'h0,    16'h0024, 1, 0); // cnt 0, stays 0
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0024, 1, 0); // cnt 0
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0024, 1, 0); // cnt 1
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0040, 1, 1); // cnt 2
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0040, 1, 1); // cnt 3
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0040, 1, 1); // cnt 3 held
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0040, 1, 1);
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 0, 16'h0,    16'h0040, 1, 1); // cnt 3 -> 2
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 0, 16'h0,    16'h0040, 1, 1); // cnt 2 -> 1
    add(16'h0023, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0024, 1, 0);
    add(16'h0023, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0045, 16'h0024, 1, 0); // retarget
    add(16'h0023, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0045, 1, 1);
    add(16'h0033, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0034, 0, 0); // alias miss
    add(16'h0033, 0, 16'h0, 1, 1, 16'h0033, 1, 16'h0050, 16'h0034, 0, 0); // replace
    add(16'h0033, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0050, 1, 1);
    add(16'h0023, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0024, 0, 0);
    add(16'h0023, 0, 16'h0, 1, 0, 16'h0023, 0, 16'h0,    16'h0024, 0, 0); // non-branch miss
    add(16'h0033, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0050, 1, 1);
    add(16'h0033, 0, 16'h0, 1, 0, 16'h0033, 0, 16'h0,    16'h0050, 1, 1); // non-branch hit
    add(16'h0033, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0034, 0, 0); // invalidated
    add(16'h0033, 0, 16'h0, 1, 1, 16'h0033, 0, 16'h0,    16'h0034, 0, 0); // miss not-taken
    add(16'h0033, 0, 16'h0, 0, 1, 16'h0033, 1, 16'h0060, 16'h0034, 0, 0); // upd_valid=0
    add(16'h0033, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0034, 0, 0);
    add(16'h0000, 0, 16'h0, 1, 1, 16'h0023, 1, 16'h0040, 16'h0001, 0, 0);
    add(16'h0023, 1, 16'h0100, 0, 0, 16'h0, 0, 16'h0,    16'h0100, 1, 1); // force wins
    add(16'h0023, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0040, 1, 1);
    add(16'hFFFF, 0, 16'h0, 0, 0, 16'h0,    0, 16'h0,    16'h0000, 0, 0); // wrap

    // Reset state while reset is held.
    @(negedge clk);
    chk("reset nextPC", 32'(nextPC), 32'h0);
    chk("reset pred_hit", 32'(pred_hit), 32'h0);
    chk("reset pred_taken", 32'(pred_taken), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      PC = vecs[i].pc; forcePC = vecs[i].fp; forcePCdata = vecs[i].fpd;
      upd_valid = vecs[i].uv; upd_is_branch = vecs[i].ub; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
      e.id = i; e.exp_next = vecs[i].exp_next;
      e.exp_hit = vecs[i].exp_hit; e.exp_taken = vecs[i].exp_taken;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("scoreboard empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d nextPC", e.id), 32'(nextPC), 32'(e.exp_next));
        chk($sformatf("vec%0d pred_hit", e.id), 32'(pred_hit), 32'(e.exp_hit));
        chk($sformatf("vec%0d pred_taken", e.id), 32'(pred_taken), 32'(e.exp_taken));
      end
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset asserted mid-cycle acts immediately; a coinciding update is dropped.
    PC = 16'h0023;
    #1;
    chk("pre-reset nextPC", 32'(nextPC), 32'h0040);
    reset = 1'b1;
    upd_valid = 1'b1; upd_is_branch = 1'b1; upd_pc = 16'h0044;
    upd_taken = 1'b1; upd_target = 16'h0070; upd_mispredict = 1'b1;
    #1;
    chk("midreset nextPC", 32'(nextPC), 32'h0);
    chk("midreset pred_hit", 32'(pred_hit), 32'h0);
    chk("midreset pred_taken", 32'(pred_taken), 32'h0);
`ifdef BTB_STATS_EN
    chk("midreset stat_lookups", 32'(stat_lookups), 32'h0);
    chk("midreset stat_hits", 32'(stat_hits), 32'h0);
    chk("midreset stat_mispredicts", 32'(stat_mispredicts), 32'h0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    PC = 16'h0044;
    #1;
    chk("dropped update nextPC", 32'(nextPC), 32'h0045);
    chk("dropped update pred_hit", 32'(pred_hit), 32'h0);
    PC = 16'h0023;
    #1;
    chk("post-reset 0023 nextPC", 32'(nextPC), 32'h0024);
    chk("post-reset 0023 pred_hit", 32'(pred_hit), 32'h0);

`ifdef BTB_STATS_EN
    // Five lookup edges on a 2-bit counter saturate at 3.
    repeat (5) @(posedge clk);
    #1;
    chk("stat_lookups sat", 32'(stat_lookups), 32'h3);
    chk("stat_hits none", 32'(stat_hits), 32'h0);
    chk("stat_mispredicts none", 32'(stat_mispredicts), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
